// File: rtl/samp_time_mgr.sv
// Emulated-time manager: advances time_curr by dt_req, clipping steps so time lands exactly on
// each sample instant, then pulses samp_strobe for one frozen cycle. Optional macro: SAMP_JITTER_EN.
`timescale 1ns/1ps
module samp_time_mgr #(
  parameter int time_bits = 32,
  parameter int dt_bits   = 16
`ifdef SAMP_JITTER_EN
  , parameter int jit_bits = 8
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [dt_bits-1:0]         dt_req,
  input  logic [time_bits-1:0]       period,
`ifdef SAMP_JITTER_EN
  input  logic signed [jit_bits-1:0] jitter,
`endif
  output logic [time_bits-1:0]       time_curr,
  output logic [dt_bits-1:0]         dt_out,
  output logic                       samp_strobe,
  output logic [15:0]                samp_count,
  output logic                       time_ovf
);

  typedef enum logic [1:0] {IDLE, RUN, STROBE, DONE} state_t;

  state_t               r_state, w_state_next;
  logic [time_bits-1:0] r_time, w_time_next;
  logic [time_bits-1:0] r_event, w_event_next;
  logic [dt_bits-1:0]   r_dt, w_dt_next;
  logic [15:0]          r_count, w_count_next;
  logic                 r_ovf, w_ovf_next;

  logic [time_bits-1:0] w_inc, w_rem, w_take, w_dt_ext;
  logic [time_bits:0]   w_sum;
  logic                 w_clip;

`ifdef SAMP_JITTER_EN
  // Two guard bits hold period + negative jitter without wrapping; non-positive steps clamp to 1 LSB.
  logic signed [time_bits+1:0] w_inc_s;
  assign w_inc_s = $signed({2'b00, period})
                 + $signed({{(time_bits+2-jit_bits){jitter[jit_bits-1]}}, jitter});
  assign w_inc   = (w_inc_s <= 0) ? time_bits'(1)
                 : (w_inc_s[time_bits] ? '1 : w_inc_s[time_bits-1:0]);
`else
  assign w_inc = period;
`endif

  assign w_dt_ext = time_bits'(dt_req);
  assign w_rem    = r_event - r_time;
  assign w_clip   = (period != '0) && (w_dt_ext >= w_rem);
  assign w_take   = w_clip ? w_rem : w_dt_ext;
  assign w_sum    = {1'b0, r_time} + {1'b0, w_take};

  always_comb begin
    w_state_next = r_state;
    w_time_next  = r_time;
    w_event_next = r_event;
    w_dt_next    = r_dt;
    w_count_next = r_count;
    w_ovf_next   = r_ovf;
    case (r_state)
      IDLE: begin
        if (en) begin
          w_event_next = w_inc;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (!en) begin
          w_dt_next = '0;
        end else if (w_sum[time_bits]) begin
          // Saturating step wins over a coincident sample event.
          w_time_next  = '1;
          w_dt_next    = dt_bits'(~r_time);
          w_ovf_next   = 1'b1;
          w_state_next = DONE;
        end else begin
          w_time_next = w_sum[time_bits-1:0];
          w_dt_next   = w_take[dt_bits-1:0];
          if (w_clip) w_state_next = STROBE;
        end
      end
      STROBE: begin
        w_dt_next    = '0;
        w_count_next = r_count + 16'd1;
        w_event_next = r_event + w_inc;
        w_state_next = RUN;
      end
      DONE: begin
        w_dt_next = '0;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_time  <= '0;
      r_event <= '0;
      r_dt    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_time  <= w_time_next;
      r_event <= w_event_next;
      r_dt    <= w_dt_next;
      r_count <= w_count_next;
      r_ovf   <= w_ovf_next;
    end
  end

  assign time_curr   = r_time;
  assign dt_out      = r_dt;
  assign samp_strobe = (r_state == STROBE);
  assign samp_count  = r_count;
  assign time_ovf    = r_ovf;

endmodule

// File: tb/tb_samp_time_mgr.sv
// Directed bench for samp_time_mgr: a 32-bit instance for scheduling and an 8-bit one for saturation.
`timescale 1ns/1ps
module tb_samp_time_mgr;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, en8 = 1'b0;
  logic [15:0] dt_req = '0;
  logic [31:0] period = '0;
  logic [7:0]  dt8 = '0, per8 = '0;
`ifdef SAMP_JITTER_EN
  logic signed [7:0] jitter = '0;
  logic signed [7:0] jitter8 = '0;
`endif

  logic [31:0] time_curr;
  logic [15:0] dt_out, samp_count, samp_count8;
  logic        samp_strobe, time_ovf, samp_strobe8, time_ovf8;
  logic [7:0]  time8, dt_out8;

  int n_vec = 0;
  int n_err = 0;
  int n_strobes;

  samp_time_mgr u_dut (
    .clk(clk), .rst(rst), .en(en), .dt_req(dt_req), .period(period),
`ifdef SAMP_JITTER_EN
    .jitter(jitter),
`endif
    .time_curr(time_curr), .dt_out(dt_out), .samp_strobe(samp_strobe),
    .samp_count(samp_count), .time_ovf(time_ovf)
  );

  samp_time_mgr #(.time_bits(8), .dt_bits(8)) u_dut8 (
    .clk(clk), .rst(rst), .en(en8), .dt_req(dt8), .period(per8),
`ifdef SAMP_JITTER_EN
    .jitter(jitter8),
`endif
    .time_curr(time8), .dt_out(dt_out8), .samp_strobe(samp_strobe8),
    .samp_count(samp_count8), .time_ovf(time_ovf8)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_main(input string tag, input logic [31:0] t, input logic [31:0] d,
                          input logic s);
    chk({tag, ".time"}, time_curr, t);
    chk({tag, ".dt"}, 32'(dt_out), d);
    chk({tag, ".strobe"}, 32'(samp_strobe), 32'(s));
  endtask

  initial begin
    // Reset state, asynchronously applied before any clock edge
    #2 rst = 1'b1;
    #2;
    chk_main("reset", 0, 0, 0);
    chk("reset.count", 32'(samp_count), 0);
    chk("reset.ovf", 32'(time_ovf), 0);
    chk("reset8.time", 32'(time8), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Clipped step onto the event at 100
    period = 32'd100; dt_req = 16'd30; en = 1'b1;
    step(); chk_main("t1.idle", 0, 0, 0);
    step(); chk_main("t1.s1", 30, 30, 0);
    step(); chk_main("t1.s2", 60, 30, 0);
    step(); chk_main("t1.s3", 90, 30, 0);
    step(); chk_main("t1.clip", 100, 10, 1);
    step(); chk_main("t1.post", 100, 0, 0);
    chk("t1.count", 32'(samp_count), 1);
    step(); chk_main("t1.s5", 130, 30, 0);

    // Enable gaps in RUN and during STROBE
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk_main("t3.hold", 130, 0, 0);
    end
    en = 1'b1;
    step(); chk_main("t3.r1", 160, 30, 0);
    step(); chk_main("t3.r2", 190, 30, 0);
    step(); chk_main("t3.clip", 200, 10, 1);
    en = 1'b0;
    step(); chk_main("t3.strobe_done", 200, 0, 0);
    chk("t3.count", 32'(samp_count), 2);
    step(); chk_main("t3.held", 200, 0, 0);

    // Large steps, every one clipped to the period
    rst = 1'b1; #1;
    chk_main("t2.rst", 0, 0, 0);
    rst = 1'b0;
    period = 32'd100; dt_req = 16'd250; en = 1'b1;
    step(); chk_main("t2.idle", 0, 0, 0);
    step(); chk_main("t2.e1", 100, 100, 1);
    step(); chk_main("t2.p1", 100, 0, 0);
    step(); chk_main("t2.e2", 200, 100, 1);
    step(); chk_main("t2.p2", 200, 0, 0);
    step(); chk_main("t2.e3", 300, 100, 1);
    step(); chk_main("t2.p3", 300, 0, 0);
    chk("t2.count", 32'(samp_count), 3);
    step(); chk_main("t2.e4", 400, 100, 1);

    // Asynchronous reset while in STROBE
    rst = 1'b1; #1;
    chk_main("t6.rst", 0, 0, 0);
    chk("t6.count", 32'(samp_count), 0);
    #1 rst = 1'b0;

    // Free-run with sampling disabled
    period = 32'd0; dt_req = 16'd7; en = 1'b1;
    step();
    n_strobes = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (samp_strobe) n_strobes++;
    end
    chk("t4.time", time_curr, 70);
    chk("t4.strobes", 32'(n_strobes), 0);
    chk("t4.count", 32'(samp_count), 0);
    dt_req = 16'd0;
    step(); chk_main("t4.dt0", 70, 0, 0);

    // Saturation on the 8-bit instance
    per8 = 8'd0; dt8 = 8'd200; en8 = 1'b1;
    step(); chk("t5.idle", 32'(time8), 0);
    step(); chk("t5.s1", 32'(time8), 200);
    chk("t5.s1dt", 32'(dt_out8), 200);
    step(); chk("t5.sat", 32'(time8), 255);
    chk("t5.satdt", 32'(dt_out8), 55);
    chk("t5.ovf", 32'(time_ovf8), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5.frozen", 32'(time8), 255);
      chk("t5.frozendt", 32'(dt_out8), 0);
      chk("t5.frozenovf", 32'(time_ovf8), 1);
    end
    rst = 1'b1; #1;
    chk("t5.rst", 32'(time8), 0);
    chk("t5.rstovf", 32'(time_ovf8), 0);
    #1 rst = 1'b0;

`ifdef SAMP_JITTER_EN
    // Jittered schedule: events at 95, 190
    en8 = 1'b0;
    period = 32'd100; jitter = -8'sd5; dt_req = 16'd50; en = 1'b1;
    step(); chk_main("tj.idle", 0, 0, 0);
    step(); chk_main("tj.s1", 50, 50, 0);
    step(); chk_main("tj.e1", 95, 45, 1);
    step(); chk_main("tj.p1", 95, 0, 0);
    step(); chk_main("tj.s2", 145, 50, 0);
    step(); chk_main("tj.e2", 190, 45, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
